// File: rtl/uart_line_pkg.sv
// Shared constants for the UART line assembler: ASCII control bytes and FSM state encoding.
package uart_line_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } line_state_e;

endpackage

// File: rtl/uart_line_echo.sv
// One-entry echo register: a byte loaded on acceptance is presented on the next cycle.
// Holds until echo_ready_i; the parent only loads when the slot is free or draining.
module uart_line_echo (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] dat_i,
    output logic [7:0] echo_data_o,
    output logic       echo_valid_o,
    input  logic       echo_ready_i
);

    logic [7:0] dat_q;
    logic       vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            dat_q <= dat_i;
            vld_q <= 1'b1;
        end else if (echo_ready_i) begin
            vld_q <= 1'b0;
        end
    end

    assign echo_data_o  = dat_q;
    assign echo_valid_o = vld_q;

endmodule

// File: rtl/uart_line_rx.sv
// Line assembler: collects bytes into a buffer and presents whole lines on CR/LF via valid/ready.
// Optional echo of every accepted byte when UART_LINE_ECHO_EN is defined.
module uart_line_rx
    import uart_line_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic                         clk_48mhz,
    input  logic                         reset_n,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [8*MAX_LEN-1:0]         line_data,
    output logic [$clog2(MAX_LEN+1)-1:0] line_len,
    output logic                         line_ovf,
    output logic                         line_valid,
    input  logic                         line_ready
`ifdef UART_LINE_ECHO_EN
    ,
    output logic [7:0]                   echo_data,
    output logic                         echo_valid,
    input  logic                         echo_ready
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [LW-1:0] MAX_CNT = LW'(MAX_LEN);

    line_state_e                state_q;
    logic [MAX_LEN-1:0][7:0]    buf_q;
    logic [LW-1:0]              cnt_q;
    logic                       ovf_q;
    logic                       vld_q;

    logic          in_acc;
    logic          is_term;
    logic          is_bs;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rm_idx;

`ifdef UART_LINE_ECHO_EN
    assign in_ready = reset_n && (state_q == ST_COLLECT) && (!echo_valid || echo_ready);

    uart_line_echo u_echo (
        .clk_i        (clk_48mhz),
        .rst_ni       (reset_n),
        .load_i       (in_acc),
        .dat_i        (in_data),
        .echo_data_o  (echo_data),
        .echo_valid_o (echo_valid),
        .echo_ready_i (echo_ready)
    );
`else
    assign in_ready = reset_n && (state_q == ST_COLLECT);
`endif

    assign in_acc  = in_valid && in_ready;
    assign is_term = (in_data == ASCII_CR) || (in_data == ASCII_LF);
    assign is_bs   = (in_data == ASCII_BS) || (in_data == ASCII_DEL);
    // Low bits of the count address the slot; at MAX_LEN the store is blocked so wrap is harmless.
    assign wr_idx  = cnt_q[IW-1:0];
    assign rm_idx  = wr_idx - IW'(1);

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_COLLECT;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_acc) begin
                        if (is_term) begin
                            if (cnt_q != '0) begin
                                state_q <= ST_EMIT;
                                vld_q   <= 1'b1;
                            end
                        end else if (is_bs) begin
                            if (cnt_q != '0) begin
                                cnt_q         <= cnt_q - LW'(1);
                                buf_q[rm_idx] <= '0;
                            end
                        end else if (cnt_q != MAX_CNT) begin
                            buf_q[wr_idx] <= in_data;
                            cnt_q         <= cnt_q + LW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (line_ready) begin
                        state_q <= ST_COLLECT;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        vld_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign line_data  = buf_q;
    assign line_len   = cnt_q;
    assign line_ovf   = ovf_q;
    assign line_valid = vld_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx with MAX_LEN = 4; echo checks build with UART_LINE_ECHO_EN.
module tb_uart_line_rx;

    localparam int ML = 4;
    localparam int LW = $clog2(ML + 1);

    logic            clk_48mhz = 1'b0;
    logic            reset_n;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [8*ML-1:0] line_data;
    logic [LW-1:0]   line_len;
    logic            line_ovf;
    logic            line_valid;
    logic            line_ready;
`ifdef UART_LINE_ECHO_EN
    logic [7:0]      echo_data;
    logic            echo_valid;
    logic            echo_ready;
    logic [7:0]      echo_q[$];
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    uart_line_rx #(.MAX_LEN(ML)) dut (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .line_data  (line_data),
        .line_len   (line_len),
        .line_ovf   (line_ovf),
        .line_valid (line_valid),
        .line_ready (line_ready)
`ifdef UART_LINE_ECHO_EN
        ,
        .echo_data  (echo_data),
        .echo_valid (echo_valid),
        .echo_ready (echo_ready)
`endif
    );

`ifdef UART_LINE_ECHO_EN
    always @(posedge clk_48mhz) begin
        if (echo_valid && echo_ready) echo_q.push_back(echo_data);
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send(input logic [7:0] b);
        logic done;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk_48mhz);
                @(negedge clk_48mhz);
                done = 1'b1;
                break;
            end
            @(negedge clk_48mhz);
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic pop();
        line_ready = 1'b1;
        @(negedge clk_48mhz);
        line_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_48mhz);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        line_ready = 1'b0;
`ifdef UART_LINE_ECHO_EN
        echo_ready = 1'b1;
`endif
        idle(2);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(line_valid), 32'd0);
        chk("rst_len", 32'(line_len), 32'd0);
        chk("rst_data", line_data, 32'h0);
        chk("rst_ovf", 32'(line_ovf), 32'd0);
        reset_n = 1'b1;
        idle(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // "ab\r\n" with line_ready low
        send(8'h61); send(8'h62); send(8'h0D);
        chk("crlf_valid", 32'(line_valid), 32'd1);
        chk("crlf_len", 32'(line_len), 32'd2);
        chk("crlf_data", line_data, 32'h0000_6261);
        chk("crlf_ovf", 32'(line_ovf), 32'd0);
        in_data = 8'h0A; in_valid = 1'b1;
        idle(3);
        chk("emit_in_ready", 32'(in_ready), 32'd0);
        chk("emit_hold_data", line_data, 32'h0000_6261);
        in_valid = 1'b0;
        pop();
        chk("after_pop_valid", 32'(line_valid), 32'd0);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_data", line_data, 32'h0);
        send(8'h0A);
        idle(2);
        chk("lf_no_line", 32'(line_valid), 32'd0);
        chk("lf_len", 32'(line_len), 32'd0);

        // Backspace / delete
        send(8'h61); send(8'h62); send(8'h63); send(8'h08);
        chk("bs_len", 32'(line_len), 32'd2);
        chk("bs_zero", line_data, 32'h0000_6261);
        send(8'h7F); send(8'h78); send(8'h0D);
        chk("bs_valid", 32'(line_valid), 32'd1);
        chk("bs_line_len", 32'(line_len), 32'd2);
        chk("bs_line", line_data, 32'h0000_7861);
        pop();

        // Backspace on empty buffer
        send(8'h08);
        chk("bs_empty_len", 32'(line_len), 32'd0);
        send(8'h0A);
        idle(2);
        chk("bs_empty_no_line", 32'(line_valid), 32'd0);

        // Overflow
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        chk("full_len", 32'(line_len), 32'd4);
        chk("full_no_ovf", 32'(line_ovf), 32'd0);
        send(8'h65);
        chk("ovf_set", 32'(line_ovf), 32'd1);
        send(8'h66); send(8'h0D);
        chk("ovf_valid", 32'(line_valid), 32'd1);
        chk("ovf_len", 32'(line_len), 32'd4);
        chk("ovf_data", line_data, 32'h6463_6261);
        chk("ovf_flag", 32'(line_ovf), 32'd1);
        pop();
        send(8'h7A); send(8'h0D);
        chk("z_len", 32'(line_len), 32'd1);
        chk("z_data", line_data, 32'h0000_007A);
        chk("z_ovf", 32'(line_ovf), 32'd0);
        pop();

        // Async reset mid-line
        send(8'h61); send(8'h62); send(8'h63);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_line_len", 32'(line_len), 32'd0);
        chk("arst_line_data", line_data, 32'h0);
        chk("arst_line_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk_48mhz);
        reset_n = 1'b1;
        idle(1);
        send(8'h71); send(8'h0D);
        chk("q1_len", 32'(line_len), 32'd1);
        chk("q1_data", line_data, 32'h0000_0071);
        // Async reset while a line is presented
        #2 reset_n = 1'b0;
        #1;
        chk("arst_emit_valid", 32'(line_valid), 32'd0);
        chk("arst_emit_len", 32'(line_len), 32'd0);
        @(negedge clk_48mhz);
        reset_n = 1'b1;
        idle(1);
        send(8'h71); send(8'h0D);
        chk("q2_valid", 32'(line_valid), 32'd1);
        chk("q2_len", 32'(line_len), 32'd1);
        pop();

        // line_ready held high in COLLECT has no effect
        line_ready = 1'b1;
        send(8'h6B);
        chk("lr_collect_len", 32'(line_len), 32'd1);
        chk("lr_collect_valid", 32'(line_valid), 32'd0);
        line_ready = 1'b0;
        send(8'h0D);
        chk("k_data", line_data, 32'h0000_006B);
        pop();

`ifdef UART_LINE_ECHO_EN
        idle(2);
        echo_q.delete();
        echo_ready = 1'b0;
        send(8'h68);
        chk("echo_vld", 32'(echo_valid), 32'd1);
        chk("echo_dat0", 32'(echo_data), 32'h68);
        in_data = 8'h69; in_valid = 1'b1;
        idle(4);
        chk("echo_stall", 32'(in_ready), 32'd0);
        echo_ready = 1'b1;
        send(8'h69);
        send(8'h0D);
        idle(3);
        chk("echo_count", 32'(echo_q.size()), 32'd3);
        if (echo_q.size() == 3) begin
            chk("echo_b0", 32'(echo_q[0]), 32'h68);
            chk("echo_b1", 32'(echo_q[1]), 32'h69);
            chk("echo_b2", 32'(echo_q[2]), 32'h0D);
        end
        chk("echo_line", line_data, 32'h0000_6968);
        pop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Line assembler between the USB CDC serial core's receive pipeline and the application command logic. It consumes the `uart_out_data/valid/ready` byte stream from `usb_uart` and collects printable bytes into a line buffer. On CR or LF it presents the whole line (packed bytes plus length) through a valid/ready handshake, so the application sees complete commands instead of single keystrokes. Optional echo returns accepted bytes toward the `usb_uart` transmit pipeline.

## Interface
- `MAX_LEN`, default 32: line buffer capacity in bytes, minimum 2.
- `clk_48mhz`, in, 1: the single clock, 48 MHz from the PLL.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, 8: received byte, driven from `uart_out_data`.
- `in_valid`, in, 1: received byte valid, driven from `uart_out_valid`.
- `in_ready`, out, 1: byte accepted when `in_valid && in_ready`; connects to `uart_out_ready`.
- `line_data`, out, 8*MAX_LEN: byte i of the line is at `[8*i+7:8*i]`. Bytes at index ≥ `line_len` read as 0.
- `line_len`, out, $clog2(MAX_LEN+1): number of stored bytes, 1..MAX_LEN.
- `line_ovf`, out, 1: the line was truncated, because more than MAX_LEN non-control bytes were received.
- `line_valid`, out, 1: a line is presented.
- `line_ready`, in, 1: consumer accepts the line.
- `echo_data`, out, 8: present only with `UART_LINE_ECHO_EN`.
- `echo_valid`, out, 1: present only with `UART_LINE_ECHO_EN`.
- `echo_ready`, in, 1: present only with `UART_LINE_ECHO_EN`.

## Operation
- States:
  - COLLECT: reset state.
  - EMIT.
- Reset values (async on `reset_n` low):
  - state = COLLECT.
  - Buffer all 0; `line_len` 0; `line_ovf` 0; `line_valid` 0; `echo_valid` 0.
  - `in_ready` forced 0 while `reset_n` is low.
- `in_ready` = (state == COLLECT) && (!echo_valid || echo_ready) with echo compiled in; otherwise (state == COLLECT). It is combinational from registers, never from `in_valid`.
- Accepted byte classes in COLLECT:
  - CR (0x0D) or LF (0x0A) with count > 0: go to EMIT and set `line_valid`.
  - CR or LF with count == 0: dropped, no line emitted. This absorbs the second byte of a CRLF pair and empty lines.
  - BS (0x08) or DEL (0x7F): if count > 0, decrement count and zero the removed byte. If count == 0, no effect. `line_ovf` is unchanged.
  - Any other byte with count < MAX_LEN: store at index count, then count+1.
  - Any other byte with count == MAX_LEN: discarded, set `line_ovf` = 1.
- EMIT:
  - `in_ready` = 0.
  - `line_data`, `line_len` and `line_ovf` are held stable while `line_valid` = 1.
  - On `line_valid && line_ready`: clear the buffer to 0, count to 0 and `line_ovf` to 0, deassert `line_valid`, return to COLLECT.
- Count arithmetic is unsigned in the `line_len` width. Count never exceeds MAX_LEN and never wraps below 0.

## Timing
- Terminator accepted at clock edge N → `line_valid` = 1 and final `line_len` visible after edge N (0-cycle latency beyond the registering edge).
- Line handshake completes at edge M → `line_valid` = 0 and `in_ready` can be 1 after edge M. At most one dead cycle between lines.
- Sustained throughput in COLLECT is one byte per clock with echo disabled, or with `echo_ready` held high.
- `line_ready` held high in COLLECT has no effect.
- A held `in_valid` with no acceptance in EMIT loses no byte; the byte stays pending upstream.
- Reset mid-line or mid-EMIT discards the partial or presented line with no emission.

## Configuration
- `UART_LINE_ECHO_EN` defined:
  - Echo ports exist.
  - Every accepted byte is copied into the echo register and `echo_valid` rises the cycle after acceptance. The register holds until `echo_ready`.
  - This includes terminators, backspaces and discarded overflow bytes.
  - An accepted byte that is echoed can still be stored.
- `UART_LINE_ECHO_EN` undefined:
  - No echo ports and no echo register.
  - `in_ready` depends only on state.

## Structure
- Shared package `uart_line_pkg` holds:
  - ASCII constants: CR, LF, BS, DEL.
  - State encoding for COLLECT and EMIT.
- The echo path is a natural sub-module: `uart_line_echo`, a one-entry valid/ready register instantiated only under `UART_LINE_ECHO_EN`.
- Buffer, count and FSM stay in the top module.

## Test plan
- Line with CRLF: send "ab\r\n" with `line_ready` = 0.
  - Response: `line_valid` = 1, `line_len` = 2, byte0 = 0x61, byte1 = 0x62, higher bytes 0, `line_ovf` = 0.
  - `in_ready` = 0 until `line_ready` pulses.
  - The trailing LF is then accepted and produces no second line.
- Backspace: send "abc", 0x08, 0x7F, "x", "\r".
  - Response: `line_len` = 2, line = "ax".
- Backspace on empty buffer: send 0x08, then "\n".
  - Response: no line, count stays 0.
- Overflow: with MAX_LEN = 4, send "abcdef\r".
  - Response: `line_len` = 4, line = "abcd", `line_ovf` = 1.
  - After the handshake, a following "z\r" gives `line_ovf` = 0 and `line_len` = 1.
- Async reset: assert `reset_n` low after "abc" and after a presented line.
  - Response: all outputs at reset values immediately. The next "q\r" yields `line_len` = 1.
- Echo (macro defined): send "hi\r" with `echo_ready` low for 5 cycles.
  - Response: `in_ready` stalls after the first byte.
  - The echo stream is 0x68, 0x69, 0x0D in order, with no loss or duplication.
